store_narrow_unit: RTL and testbench

//  - Store-path counterpart of the load sign/zero extender. Narrows a 32-bit register value to byte, halfword or word.
//  - Writes the value into a word-wide data memory. Sub-word stores use read-modify-write.
//  - Sits between the multicycle datapath (SB/SH/SW issue) and the word-addressed data memory port.
//  - Flags misaligned stores and does not issue any memory access for them.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/store_lane_merge.sv | 30 +++
 rtl/store_narrow_unit.sv | 126 ++++++++++++
 tb/tb_store_narrow_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access-size encodings and store-unit FSM states.
// The size encodings are common to the load extender and the store narrower.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } st_state_e;

  // Reserved size never has a legal alignment.
  function automatic logic st_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte/half/word merge of new store data into an old memory word.
// BIG_ENDIAN mirrors the lane order so the lowest byte address holds the MSBs.
module store_lane_merge
  import cpu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] old_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] word_o
);

  logic [1:0] lane;
  logic       half_hi;

  always_comb begin
    lane    = BIG_ENDIAN ? ~off_i : off_i;
    half_hi = BIG_ENDIAN ? ~off_i[1] : off_i[1];
    word_o  = old_i;
    case (size_i)
      SZ_BYTE: word_o[{lane, 3'b000} +: 8]     = data_i[7:0];
      SZ_HALF: word_o[{half_hi, 4'b0000} +: 16] = data_i[15:0];
      SZ_WORD: word_o = data_i;
      default: word_o = old_i;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrower: SW issues a single write, SB/SH read-modify-write the word.
// Misaligned or reserved-size stores are rejected without touching memory.
module store_narrow_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  st_state_e         state_q, state_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, wdata_q, wdata_d, merged;
  logic [1:0]        size_q, size_d, off_q, off_d;

  store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
    .old_i  (mem_rdata),
    .data_i (data_q),
    .size_i (size_q),
    .off_i  (off_q),
    .word_o (merged)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    case (state_q)
      ST_IDLE: if (st_valid) begin
        size_d = st_size;
        off_d  = st_addr[1:0];
        data_d = st_data;
        if (st_misaligned(st_size, st_addr[1:0])) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          err_d  = 1'b0;
          addr_d = {st_addr[ADDR_W-1:2], 2'b00};
          if (st_size == SZ_WORD) begin
            we_d    = 1'b1;
            wdata_d = st_data;
            state_d = ST_WRITE;
          end else begin
            we_d    = 1'b0;
            state_d = ST_READ;
          end
        end
      end
      // req rises one cycle after entering a phase and drops the cycle after ack,
      // which leaves the single req-low cycle between the read and write phases.
      ST_READ: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b1;
          wdata_d = merged;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!req_q) req_d = 1'b1;
        else if (mem_ack) begin
          req_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  assign st_ready  = (state_q == ST_IDLE);
  assign st_done   = (state_q == ST_RESP);
  assign st_err    = st_done && err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: LE and BE instances share stimulus and memory;
// a per-store timeline model predicts every output cycle by cycle.
module tb_store_narrow_unit;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic [1:0]  st_size = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        st_ready, st_done, st_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        b_st_ready, b_st_done, b_st_err, b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(st_done), .st_err(st_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(b_st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_done(b_st_done), .st_err(b_st_err), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Byte-addressed view: offset o of the word lives in lane o (LE) or 3-o (BE).
  function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] off,
                                            input bit be);
    logic [7:0] b [4];
    logic [7:0] v;
    int o;
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (sz == 2'b00) begin
      o = be ? 3 - int'(off) : int'(off);
      b[o] = d[7:0];
    end else if (sz == 2'b01) begin
      for (int i = 0; i < 2; i++) begin
        o = 2 * int'(off[1]) + i;
        v = be ? d[15 - 8*i -: 8] : d[8*i +: 8];
        b[be ? 3 - o : o] = v;
      end
    end else begin
      return d;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Model state for the one outstanding store
  bit          m_busy = 1'b0;
  int          m_a = 0, m_kind = 0, m_d = 1, acc_cnt = 0, ack_dly = 1, last_lat = -1;
  logic [31:0] m_addr = '0, m_wle = '0, m_wbe = '0;
  logic [31:0] mem [16] = '{default: 32'h0};

  always @(negedge clk) begin : cmp
    int k;
    bit e_rdy, e_done, e_err, e_req, e_we, chk_w;
    e_rdy = 1; e_done = 0; e_err = 0; e_req = 0; e_we = 0; chk_w = 0; k = 0;
    if (cyc >= 1) begin
      if (m_busy) begin
        k = cyc - m_a;
        e_rdy = 0;
        case (m_kind)
          0: if (k == 0) begin e_done = 1; e_err = 1; end
          1: begin
            if (k >= 1 && k <= m_d) begin e_req = 1; e_we = 1; chk_w = 1; end
            if (k == m_d + 1) e_done = 1;
          end
          default: begin
            if (k >= 1 && k <= m_d) e_req = 1;
            if (k >= m_d + 2 && k <= 2*m_d + 1) begin e_req = 1; e_we = 1; chk_w = 1; end
            if (k == 2*m_d + 2) e_done = 1;
          end
        endcase
      end
      chk("st_ready", st_ready, e_rdy);
      chk("st_done", st_done, e_done);
      chk("mem_req", mem_req, e_req);
      chk("be_st_ready", b_st_ready, e_rdy);
      chk("be_st_done", b_st_done, e_done);
      chk("be_mem_req", b_mem_req, e_req);
      if (e_done) begin
        chk("st_err", st_err, e_err);
        chk("be_st_err", b_st_err, e_err);
      end
      if (e_req) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("be_mem_we", b_mem_we, e_we);
        chk("be_mem_addr", b_mem_addr, m_addr);
      end
      if (chk_w) begin
        chk("mem_wdata", mem_wdata, m_wle);
        chk("be_mem_wdata", b_mem_wdata, m_wbe);
      end
      if (st_done && m_busy) last_lat = cyc + 1 - m_a;
      if (m_busy && e_done) m_busy = 0;
    end
    if (!rst_n) m_busy = 0;
    else if (st_valid && e_rdy) begin
      m_busy = 1;
      m_a = cyc + 1;
      m_d = ack_dly;
      acc_cnt++;
      m_addr = {st_addr[31:2], 2'b00};
      if (st_size == 2'b11 || (st_size == 2'b01 && st_addr[0]) ||
          (st_size == 2'b10 && st_addr[1:0] != 2'b00)) m_kind = 0;
      else if (st_size == 2'b10) begin
        m_kind = 1; m_wle = st_data; m_wbe = st_data;
      end else begin
        m_kind = 2;
        m_wle = exp_merge(mem[st_addr[5:2]], st_data, st_size, st_addr[1:0], 1'b0);
        m_wbe = exp_merge(mem[st_addr[5:2]], st_data, st_size, st_addr[1:0], 1'b1);
      end
    end
  end

  // Memory responder: ack after m_d cycles of req; writes land on the write ack.
  int          wcnt = 0, req_cycles = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_be = '0;
  logic        pre_go = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (pre_go) mem[pre_idx] = pre_val;
    if (rst_n && mem_req) begin
      req_cycles++;
      if (wcnt >= m_d - 1) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          mem[mem_addr[5:2]] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_be = b_mem_wdata;
        end else begin
          mem_rdata = mem[mem_addr[5:2]];
          last_rd_addr = mem_addr;
        end
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic preset(input logic [3:0] i, input logic [31:0] v);
    @(posedge clk); #1;
    pre_idx = i; pre_val = v; pre_go = 1'b1;
    @(posedge clk); #1;
    pre_go = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int dly, input bit pulse);
    int n0;
    bit ok;
    @(posedge clk); #1;
    ack_dly = dly;
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = sz;
    n0 = acc_cnt; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) begin ok = 1; break; end
    end
    chk("accept_timeout", ok, 1'b1);
    st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
    if (pulse) begin
      repeat (3) @(posedge clk);
      #1 st_valid = 1'b1;
      @(posedge clk); #1;
      st_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!m_busy) begin ok = 1; break; end
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rc;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", st_ready, 1'b1);
    chk("rst_done", st_done, 1'b0);
    chk("rst_err", st_err, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_store(32'h100, 32'hDEADBEEF, 2'b10, 1, 0); wait_idle();
    chk("sw_mem", mem[0], 32'hDEADBEEF);
    chk("sw_waddr", last_wr_addr, 32'h100);
    chk("sw_lat", last_lat, 3);

    preset(0, 32'h11223344);
    do_store(32'h103, 32'h000000AA, 2'b00, 1, 0); wait_idle();
    chk("sb_raddr", last_rd_addr, 32'h100);
    chk("sb_mem", mem[0], 32'hAA223344);
    chk("sb_be_wdata", last_wr_be, 32'h112233AA);
    chk("sb_lat", last_lat, 5);

    preset(0, 32'h11223344);
    do_store(32'h102, 32'h00005566, 2'b01, 1, 0); wait_idle();
    chk("sh_mem", mem[0], 32'h55663344);
    chk("sh_be_wdata", last_wr_be, 32'h11225566);

    rc = req_cycles;
    do_store(32'h101, 32'h1234, 2'b01, 1, 0); wait_idle();
    chk("sh_mis_lat", last_lat, 1);
    do_store(32'h102, 32'h1234, 2'b10, 1, 0); wait_idle();
    chk("sw_mis_lat", last_lat, 1);
    do_store(32'h100, 32'h1234, 2'b11, 1, 0); wait_idle();
    chk("rsvd_lat", last_lat, 1);
    chk("err_no_req", req_cycles, rc);

    preset(1, 32'hCAFEF00D);
    do_store(32'h105, 32'h12345677, 2'b00, 5, 1); wait_idle();
    chk("sb_slow_mem", mem[1], 32'hCAFE770D);
    chk("sb_slow_lat", last_lat, 13);

    preset(2, 32'h0BADBAD0);
    do_store(32'h108, 32'h12345678, 2'b10, 5, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle();
    chk("rst_abort_mem", mem[2], 32'h0BADBAD0);
    do_store(32'h10C, 32'h600DF00D, 2'b10, 1, 0); wait_idle();
    chk("post_rst_mem", mem[3], 32'h600DF00D);
    chk("post_rst_lat", last_lat, 3);

    for (int i = 0; i < 16; i++) preset(4'(i), $urandom);
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'h100 + $urandom_range(0, 63);
      do_store(a, $urandom, 2'($urandom_range(0, 3)), $urandom_range(1, 4),
               ($urandom_range(0, 7) == 0));
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
